// File: rtl/nibble_serial_addsub_pkg.sv
// Shared ALU definitions: state encoding, opcode values and slice width.
package nibble_serial_addsub_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_LO   = ST_LO,
    S_HI   = ST_HI,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/nibble_serial_addsub_cla_nibble_add.sv
// 4-bit carry-lookahead adder slice, purely combinational.
module cla_nibble_add
  import nibble_serial_addsub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:1] c;

  assign g = x & y;
  assign p = x ^ y;

  // Every carry is expanded from generate/propagate so no carry ripples.
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
  assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s = p ^ {c[3:1], ci};

endmodule

// File: rtl/nibble_serial_addsub.sv
// 8-bit add/subtract that reuses one 4-bit lookahead slice over two cycles,
// low nibble first, then high nibble; result and flags are registered.
//
// state | meaning
// IDLE  | waiting for start; operands latched when start=1
// LO    | slice works on bits [3:0], low nibble and carry c4 captured
// HI    | slice works on bits [7:4], result and flags written
// DONE  | done pulse for one cycle, then back to IDLE
module nibble_serial_addsub
  import nibble_serial_addsub_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op_sub,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              cout,
  output logic              zero,
  output logic              negative,
  output logic              overflow
);

  state_t state, state_next;

  logic [DATA_W-1:0]   a_l;
  logic [DATA_W-1:0]   b_l;
  logic                op_sub_l;
  logic                c4;
  logic [NIBBLE_W-1:0] lo_nib;

  logic [NIBBLE_W-1:0] slice_x;
  logic [NIBBLE_W-1:0] slice_y;
  logic                slice_ci;
  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_co;
  logic [DATA_W-1:0]   full_r;
  logic                b7_eff;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state sequencing and status outputs decoded from the state.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      S_IDLE: if (start) state_next = S_LO;
      S_LO: begin
        busy       = 1'b1;
        state_next = S_HI;
      end
      S_HI: begin
        busy       = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
    endcase
  end

  // Slice input mux: subtract is a + ~b + 1, the +1 entering as the low carry-in.
  always_comb begin
    slice_x  = a_l[NIBBLE_W-1:0];
    slice_y  = b_l[NIBBLE_W-1:0] ^ {NIBBLE_W{op_sub_l}};
    slice_ci = op_sub_l;
    if (state == S_HI) begin
      slice_x  = a_l[DATA_W-1:NIBBLE_W];
      slice_y  = b_l[DATA_W-1:NIBBLE_W] ^ {NIBBLE_W{op_sub_l}};
      slice_ci = c4;
    end
  end

  cla_nibble_add u_slice (
    .x  (slice_x),
    .y  (slice_y),
    .ci (slice_ci),
    .s  (slice_s),
    .co (slice_co)
  );

  assign full_r = {slice_s, lo_nib};
  assign b7_eff = b_l[DATA_W-1] ^ op_sub_l;

  // Operand latch, inter-nibble carry and result/flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_l      <= '0;
      b_l      <= '0;
      op_sub_l <= 1'b0;
      c4       <= 1'b0;
      lo_nib   <= '0;
      result   <= '0;
      cout     <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        a_l      <= a;
        b_l      <= b;
        op_sub_l <= op_sub;
      end
      if (state == S_LO) begin
        lo_nib <= slice_s;
        c4     <= slice_co;
      end
      if (state == S_HI) begin
        result   <= full_r;
        cout     <= slice_co;
        zero     <= (full_r == '0);
        negative <= slice_s[NIBBLE_W-1];
        overflow <= (a_l[DATA_W-1] == b7_eff) && (slice_s[NIBBLE_W-1] != a_l[DATA_W-1]);
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Self-checking bench: directed cases plus randomized operations against
// an arithmetic reference model.
module tb_nibble_serial_addsub;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       op_sub = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       busy, done, cout, zero, negative, overflow;
  logic [7:0] result;

  int checks = 0;
  int errors = 0;
  logic [7:0] prev_r = 8'h00;

  always #5 clk = ~clk;

  nibble_serial_addsub dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_sub   (op_sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .zero     (zero),
    .negative (negative),
    .overflow (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: returns {overflow, negative, zero, cout, result[7:0]}.
  function automatic logic [11:0] model(input logic [7:0] ia, input logic [7:0] ib, input logic sub);
    int ua, ub, sa, sb, t, st;
    logic [7:0] r;
    logic c, v;
    ua = ia;
    ub = ib;
    sa = $signed(ia);
    sb = $signed(ib);
    t  = sub ? ua - ub : ua + ub;
    st = sub ? sa - sb : sa + sb;
    r  = t[7:0];
    c  = sub ? (ua >= ub) : (ua + ub > 255);
    v  = (st > 127) || (st < -128);
    return {v, r[7], (r == 8'h00), c, r};
  endfunction

  task automatic check_outputs(input string tag, input logic [11:0] m);
    check({tag, "_result"}, result, m[7:0]);
    check({tag, "_cout"}, cout, m[8]);
    check({tag, "_zero"}, zero, m[9]);
    check({tag, "_neg"}, negative, m[10]);
    check({tag, "_ovf"}, overflow, m[11]);
  endtask

  // One full operation with operands scrambled after acceptance.
  task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib, input logic isub);
    logic [11:0] m;
    m = model(ia, ib, isub);
    @(negedge clk);
    a = ia; b = ib; op_sub = isub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); op_sub = 1'($urandom);
    check({tag, "_busy_lo"}, busy, 1);
    check({tag, "_hold_lo"}, result, prev_r);
    @(posedge clk); #1;
    check({tag, "_busy_hi"}, busy, 1);
    check({tag, "_done_hi"}, done, 0);
    check({tag, "_hold_hi"}, result, prev_r);
    @(posedge clk); #1;
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_done"}, busy, 0);
    check_outputs(tag, m);
    @(posedge clk); #1;
    check({tag, "_done_low"}, done, 0);
    check({tag, "_busy_idle"}, busy, 0);
    check({tag, "_hold_idle"}, result, m[7:0]);
    prev_r = m[7:0];
  endtask

  initial begin
    logic [11:0] m;
    logic [7:0] exp_busy, exp_done;
    int done_cnt;

    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check_outputs("rst", 12'h000);
    @(negedge clk);
    rst = 1'b0;

    // idle with start low: nothing happens
    repeat (3) @(posedge clk);
    #1 check("idle_busy", busy, 0);

    run_op("sub_basic", 8'h37, 8'h12, 1'b1);
    check("basic_exact", result, 8'h25);

    // cross-nibble borrow; carry register after LO must be 0
    @(negedge clk);
    a = 8'h10; b = 8'h01; op_sub = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 check("borrow_c4", dut.c4, 0);
    @(posedge clk); #1 check_outputs("borrow", model(8'h10, 8'h01, 1'b1));
    check("borrow_exact", result, 8'h0F);
    @(posedge clk); #1;
    prev_r = 8'h0F;

    run_op("underflow", 8'h00, 8'h01, 1'b1);
    check("underflow_exact", {overflow, negative, cout, result}, {1'b0, 1'b1, 1'b0, 8'hFF});
    run_op("sub_ovf", 8'h80, 8'h01, 1'b1);
    check("sub_ovf_exact", {overflow, cout, result}, {1'b1, 1'b1, 8'h7F});
    run_op("add_ovf", 8'h7F, 8'h01, 1'b0);
    check("add_ovf_exact", {overflow, negative, cout, result}, {1'b1, 1'b1, 1'b0, 8'h80});
    run_op("add_wrap", 8'hFF, 8'h01, 1'b0);
    check("add_wrap_exact", {overflow, zero, cout, result}, {1'b0, 1'b1, 1'b1, 8'h00});

    // start held high: second op accepted only after DONE
    exp_busy = 8'b0011_0011;   // bit i = after edge Ei
    exp_done = 8'b0100_0100;
    done_cnt = 0;
    @(negedge clk);
    a = 8'h05; b = 8'h03; op_sub = 1'b1; start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i == 0) a = 8'hAA;
      if (i == 4) start = 1'b0;
      check($sformatf("hold_busy_e%0d", i), busy, exp_busy[i]);
      check($sformatf("hold_done_e%0d", i), done, exp_done[i]);
      if (done) done_cnt++;
      if (i == 2) check("hold_first", result, 8'h02);
      if (i == 6) check("hold_second", result, model(8'hAA, 8'h03, 1'b1) & 12'h0FF);
    end
    check("hold_done_count", done_cnt, 2);
    prev_r = 8'hA7;

    // reset in the middle of an operation
    run_op("pre_rst", 8'h37, 8'h12, 1'b1);
    @(negedge clk);
    a = 8'h50; b = 8'h20; op_sub = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check_outputs("midrst", 12'h000);
    done_cnt = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("midrst_no_done", done_cnt, 0);
    check("midrst_idle", busy, 0);
    prev_r = 8'h00;
    run_op("post_rst", 8'h09, 8'h07, 1'b0);
    check("post_rst_exact", result, 8'h10);

    // randomized operations with random idle gaps
    for (int i = 0; i < 60; i++) begin
      run_op($sformatf("rnd%0d", i), 8'($urandom), 8'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
